// File: rtl/fifo_rd_adapter.sv
// Read-side consumer for the 16x8 FIFO: issues reads, tracks the one-cycle read latency and
// re-times the data as a valid/ready stream. Define FIFO_RD_STATS_EN to add rd/stall counters.
module fifo_rd_adapter #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           ff_empty,
  input  logic                           ff_full,
  input  logic                           ff_wr,
  input  logic [DATA_W-1:0]              ff_dout,
  output logic                           ff_rd,
  output logic                           m_valid,
  output logic [DATA_W-1:0]              m_data,
  input  logic                           m_ready,
  output logic                           busy,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occ,
  output logic [1:0]                     state_dbg,
  output logic [15:0]                    rd_count,
  output logic [15:0]                    stall_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic               inflight;
  logic [DATA_W-1:0]  mem [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               credit_ok;
  logic               rd_acc;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: a byte transfers on every rising edge where m_valid and m_ready are both high;
  // once m_valid rises, m_valid and m_data are held until that transfer.
  // Credit counts the byte already requested from the FIFO, so a capture always has room.
  assign credit_ok = ({1'b0, occ} + (OCC_W + 1)'(inflight)) < (OCC_W + 1)'(BUF_DEPTH);
  assign ff_rd     = !rst && (state == RUN) && !ff_empty && credit_ok;
  // A FIFO write that is not blocked by full takes the port and the read is lost.
  assign rd_acc    = ff_rd && !ff_empty && !(ff_wr && !ff_full);
  assign push      = inflight;
  assign pop       = m_valid && m_ready;

  assign m_valid   = (occ != '0);
  assign m_data    = m_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ff_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= rd_acc;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= (occ != '0 || inflight) ? DRAIN : IDLE;
        DRAIN: begin
          if (en) state <= RUN;
          else if (occ == '0 && !inflight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && occ == OCC_W'(BUF_DEPTH)));

`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rd_acc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (m_valid && !m_ready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign rd_count    = rd_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign rd_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: behavioural 16x8 FIFO environment, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_fifo_rd_adapter;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, en = 1'b0, ff_empty = 1'b1, ff_full = 1'b0, ff_wr = 1'b0;
  logic [DATA_W-1:0] ff_dout = '0, wr_data = '0, m_data;
  logic              ff_rd, m_valid, m_ready = 1'b0, busy;
  logic [2:0]        occ;
  logic [1:0]        state_dbg;
  logic [15:0]       rd_count, stall_count;

  fifo_rd_adapter #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .ff_empty(ff_empty), .ff_full(ff_full), .ff_wr(ff_wr),
    .ff_dout(ff_dout), .ff_rd(ff_rd), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .occ(occ), .state_dbg(state_dbg), .rd_count(rd_count),
    .stall_count(stall_count)
  );

  // environment FIFO and reference model
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] dlv_q[$];
  logic [DATA_W-1:0] m_pend = '0;
  int  m_st = S_IDLE, m_rdc = 0, m_stallc = 0;
  bit  m_infl = 1'b0, chk_en = 1'b0;
  int  checks = 0, errors = 0, cyc = 0;
  int  rd_hi, rd_run, rd_max, first_rd, first_dlv, last_dlv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_flags();
    ff_empty = (fifo_q.size() == 0);
    ff_full  = (fifo_q.size() == 16);
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(DATA_W'(base + i));
    set_flags();
  endtask

  task automatic clear_log();
    dlv_q.delete();
    rd_hi = 0; rd_run = 0; rd_max = 0; first_rd = -1; first_dlv = -1; last_dlv = -1;
  endtask

  // one clock: check outputs mid-cycle, then advance environment and model after the edge
  task automatic tick();
    bit exp_rd, exp_v, s_rd, s_wr, s_rst, s_rdy, s_en, f_empty, f_full, acc_exp, infl_pre;
    int occ_pre;
    @(negedge clk);
    f_empty = (fifo_q.size() == 0);
    f_full  = (fifo_q.size() == 16);
    exp_rd  = !rst && m_st == S_RUN && !f_empty && (exp_q.size() + int'(m_infl) < BUF_DEPTH);
    exp_v   = (exp_q.size() != 0);
    if (chk_en) begin
      check("ff_rd", ff_rd, exp_rd);
      check("m_valid", m_valid, exp_v);
      if (exp_v) check("m_data", m_data, exp_q[0]);
      check("occ", occ, exp_q.size());
      check("busy", busy, m_st != S_IDLE);
      check("state_idle", state_dbg == 2'd0, m_st == S_IDLE);
`ifdef FIFO_RD_STATS_EN
      check("rd_count", rd_count, m_rdc);
      check("stall_count", stall_count, m_stallc);
`else
      check("rd_count", rd_count, 0);
      check("stall_count", stall_count, 0);
`endif
      if (ff_rd) begin
        rd_hi++; rd_run++;
        if (rd_run > rd_max) rd_max = rd_run;
        if (first_rd < 0) first_rd = cyc;
      end else rd_run = 0;
      if (!rst && m_valid && m_ready) begin
        dlv_q.push_back(m_data);
        if (first_dlv < 0) first_dlv = cyc;
        last_dlv = cyc;
      end
    end
    s_rd = ff_rd; s_wr = ff_wr; s_rst = rst; s_rdy = m_ready; s_en = en;
    acc_exp  = exp_rd && !(s_wr && !f_full);
    occ_pre  = exp_q.size();
    infl_pre = m_infl;
    @(posedge clk);
    #1;
    if (s_rst) begin
      fifo_q.delete(); exp_q.delete();
      ff_dout = '0; m_infl = 1'b0; m_st = S_IDLE; m_rdc = 0; m_stallc = 0;
    end else begin
      if (exp_v && s_rdy) void'(exp_q.pop_front());
      if (m_infl) exp_q.push_back(m_pend);
      if (acc_exp) m_pend = fifo_q[0];
      m_infl = acc_exp;
      if (acc_exp && m_rdc < 65535) m_rdc++;
      if (exp_v && !s_rdy && m_stallc < 65535) m_stallc++;
      case (m_st)
        S_IDLE:  if (s_en) m_st = S_RUN;
        S_RUN:   if (!s_en) m_st = (occ_pre != 0 || infl_pre) ? S_DRAIN : S_IDLE;
        default: if (s_en) m_st = S_RUN;
                 else if (occ_pre == 0 && !infl_pre) m_st = S_IDLE;
      endcase
      if (s_wr && !f_full) fifo_q.push_back(wr_data);
      else if (s_rd && !f_empty) ff_dout = fifo_q.pop_front();
    end
    set_flags();
    cyc++;
  endtask

  initial begin
    clear_log();
    // reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_occ", occ, 0);
    check("rst_busy", busy, 0);
    check("rst_ff_rd", ff_rd, 0);

    // throughput: 16 preloaded bytes at one per cycle
    preload(16, 1);
    en = 1'b1; m_ready = 1'b1;
    clear_log();
    for (int i = 0; i < 22; i++) tick();
    check("tp_rd_cycles", rd_hi, 16);
    check("tp_rd_consec", rd_max, 16);
    check("tp_latency", first_dlv - first_rd, 2);
    check("tp_dlv_n", dlv_q.size(), 16);
    check("tp_dlv_span", last_dlv - first_dlv, 15);
    for (int i = 0; i < dlv_q.size(); i++) check("tp_byte", dlv_q[i], i + 1);
    check("tp_empty", ff_empty, 1);
    check("tp_busy", busy, 1);

    // write collision: write takes the port, read retried
    clear_log();
    ff_wr = 1'b1; wr_data = 8'hA5;
    tick();
    wr_data = 8'h5A;
    tick();
    ff_wr = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("col_rd_cycles", rd_hi, 3);
    check("col_dlv_n", dlv_q.size(), 2);
    if (dlv_q.size() == 2) begin
      check("col_byte0", dlv_q[0], 8'hA5);
      check("col_byte1", dlv_q[1], 8'h5A);
    end
    check("col_fifo_cnt", fifo_q.size(), 0);

    // backpressure
    clear_log();
    m_ready = 1'b0;
    preload(8, 8'h40);
    for (int i = 0; i < 8; i++) tick();
    check("bp_occ", occ, 4);
    check("bp_ff_rd", ff_rd, 0);
    check("bp_fifo_left", fifo_q.size(), 4);
    check("bp_head", m_data, 8'h40);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("bp_dlv_n", dlv_q.size(), 8);
    for (int i = 0; i < dlv_q.size(); i++) check("bp_byte", dlv_q[i], 8'h40 + i);

    // drain: en drops one cycle after a read
    clear_log();
    preload(3, 8'h70);
    tick();
    en = 1'b0;
    tick();
    check("dr_busy", busy, 1);
    for (int i = 0; i < 6; i++) tick();
    check("dr_idle", busy, 0);
    check("dr_dlv_n", dlv_q.size(), 2);
    check("dr_fifo_left", fifo_q.size(), 1);
    fifo_q.delete(); set_flags();

    // reset mid-stream with occ=3 and a read in flight
    en = 1'b1; m_ready = 1'b0;
    preload(6, 8'h90);
    for (int i = 0; i < 10 && !(exp_q.size() == 3 && m_infl); i++) tick();
    check("mr_setup_occ", occ, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check("mr_m_valid", m_valid, 0);
    check("mr_occ", occ, 0);
    check("mr_busy", busy, 0);
    check("mr_ff_rd", ff_rd, 0);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      m_ready = ($urandom_range(0, 3) != 0);
      ff_wr   = ($urandom_range(0, 2) == 0);
      wr_data = DATA_W'($urandom);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; ff_wr = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("end_occ", occ, 0);
    check("end_busy", busy, 0);
    check("end_fifo", fifo_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_adapter.md
Name: fifo_rd_adapter

Overview:
- Read-side consumer for the team's 16x8 FIFO.
- Drives the FIFO read strobe, tracks the FIFO's one-cycle registered read latency, and mirrors the FIFO's write-over-read priority so it knows exactly which reads took effect.
- Presents the data as a valid/ready byte stream to downstream logic through a small internal buffer, with sustained one-byte-per-cycle throughput.

Parameters:
- DATA_W, 8, width of the FIFO data word and of the stream data.
- BUF_DEPTH, 4, internal output buffer entries. Minimum 2; at least 3 is needed for full throughput.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset; shared with the FIFO.
- en  in  1  high: issue FIFO reads; low: stop issuing and drain outstanding data.
- ff_empty  in  1  FIFO empty flag.
- ff_full  in  1  FIFO full flag.
- ff_wr  in  1  FIFO write strobe, monitored only.
- ff_dout  in  DATA_W  FIFO registered read data.
- ff_rd  out  1  FIFO read strobe.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_W  stream data.
- m_ready  in  1  downstream ready.
- busy  out  1  high whenever the state is not IDLE.
- occ  out  $clog2(BUF_DEPTH+1)  current buffer occupancy.

Behaviour:
- Reset: one clk with rst=1 sets state=IDLE, occ=0, inflight=0, m_valid=0, m_data=0, busy=0, buffer pointers=0. ff_rd is forced 0 while rst=1.
- Reset mid-operation: inflight and buffered bytes are discarded, with no stream output on the following cycle. The FIFO resets on the same edge.
- States:
  - IDLE: en=0, occ=0, inflight=0. en=1 -> RUN.
  - RUN: reads may be issued. en=0 -> DRAIN if occ!=0 or inflight=1, else -> IDLE.
  - DRAIN: no reads; buffered data keeps flowing out. en=1 -> RUN. occ=0 and inflight=0 -> IDLE.
- Read issue (combinational): ff_rd = !rst & state==RUN & !ff_empty & (occ + inflight < BUF_DEPTH).
- Read acceptance mirrors the FIFO priority: rd_acc = ff_rd & !ff_empty & !(ff_wr & !ff_full). When a write wins the port, the read is lost and is simply retried on a later cycle.
- Latency:
  - rd_acc at edge N sets inflight=1. ff_dout is valid after edge N and is captured into the buffer at edge N+1.
  - Earliest m_valid is 2 cycles after ff_rd is asserted.
  - inflight clears at capture unless a new rd_acc occurs on the same edge.
- Buffer:
  - Circular with wrap-around at BUF_DEPTH. m_data shows the head entry; m_valid = (occ!=0).
  - Pop on m_valid & m_ready. Push and pop on the same edge leave occ unchanged.
  - The credit rule guarantees no overflow. Pushing when occ==BUF_DEPTH is an assertion failure.
- Stream rule: once m_valid=1, m_valid and m_data hold until the pop.
- Ordering: bytes leave in exact FIFO read order; no duplicates, no drops.
- FIFO empty at the issue cycle: no read; ff_rd=0.
- en deasserted while inflight=1: the captured byte is still delivered in DRAIN.

Optional Feature:
- Macro FIFO_RD_STATS_EN.
- Defined: adds outputs rd_count[15:0] and stall_count[15:0], both reset to 0 and saturating at 16'hFFFF.
  - rd_count increments on each rd_acc.
  - stall_count increments on each cycle with m_valid & !m_ready.
- Undefined: neither counter exists and both outputs are tied to 0.

Test Plan:
- Throughput: FIFO preloaded with 0x01..0x10, en=1, m_ready=1 -> ff_rd high for 16 consecutive cycles; m_data = 0x01..0x10 on 16 consecutive cycles starting 2 cycles after the first ff_rd; ff_empty then high; state returns to RUN idle-wait.
- Write collision: FIFO holds 0xA5; same-cycle ff_wr=1 with ff_full=0 and ff_rd=1 -> no capture; retry next cycle; 0xA5 delivered once only; FIFO cnt correct.
- Backpressure: 8 bytes queued, m_ready=0 -> occ reaches 4, ff_rd stays 0, m_data holds the first byte stable. m_ready=1 -> remaining bytes delivered in order, no loss.
- Drain: en drops one cycle after a read -> state DRAIN, busy=1; inflight byte and buffered bytes delivered; then IDLE, busy=0, no further ff_rd.
- Reset mid-stream: rst for 1 cycle with occ=3 and inflight=1 -> next cycle m_valid=0, occ=0, busy=0, ff_rd=0.
- Stats (FIFO_RD_STATS_EN defined): 5 reads accepted, 3 cycles with m_ready=0 while valid -> rd_count=5, stall_count=3.
